// File: rtl/read_unit_if.sv
// Read-side bundle for read_unit: read request and write pointer in, memory strobe, pointer and status out.
// The master side drives requests; the slave side is the read unit itself.
interface read_unit_if #(
    parameter int N = 16
);
    logic         rdEn;
    logic [N-1:0] wrPtr;
    logic [N-1:0] rdPtr;
    logic [N-2:0] rdAddr;
    logic         memRdEn;
    logic         rdValid;
    logic         fifoEmpty;
    logic         almostEmpty;
    logic [N-1:0] fillLevel;
    logic         rdUnderflow;

    modport master (
        output rdEn, wrPtr,
        input  rdPtr, rdAddr, memRdEn, rdValid, fifoEmpty, almostEmpty, fillLevel, rdUnderflow
    );

    modport slave (
        input  rdEn, wrPtr,
        output rdPtr, rdAddr, memRdEn, rdValid, fifoEmpty, almostEmpty, fillLevel, rdUnderflow
    );
endinterface

// File: rtl/read_unit.sv
// FIFO read-side controller: wrap-bit read pointer, memory read strobe, 1-cycle data-valid and occupancy flags.
// Optional sticky underflow flag is built only when READ_UNIT_UNDERFLOW_EN is defined.
module read_unit #(
    parameter int          N         = 16,
    parameter int unsigned DEPTH     = 16'b0110_1000_0000_0000,
    parameter int unsigned AE_THRESH = 16
) (
    input  logic       rdClk,
    input  logic       rdRst,
    read_unit_if.slave bus
);

    localparam logic [N-2:0] LAST_ADDR = (N-1)'(DEPTH - 1);
    localparam logic [N-2:0] ADDR_ONE  = (N-1)'(1);
    localparam logic [N-1:0] DEPTH_N   = N'(DEPTH);

    logic [N-1:0] rdPtr_q;
    logic [N-1:0] rdPtr_d;
    logic         rdValid_q;

    logic [N-2:0] ptrLow;
    logic [N-2:0] wrLow;
    logic         ptrWrap;
    logic         wrWrap;
    logic         empty;
    logic         accept;
    logic [N-1:0] fill;

    assign ptrLow  = rdPtr_q[N-2:0];
    assign ptrWrap = rdPtr_q[N-1];
    assign wrLow   = bus.wrPtr[N-2:0];
    assign wrWrap  = bus.wrPtr[N-1];

    assign empty  = (rdPtr_q == bus.wrPtr);
    assign accept = bus.rdEn & ~empty & ~rdRst;

    // Addresses run 0..DEPTH-1, which need not be a power of two, so rollover is explicit.
    always_comb begin
        rdPtr_d = rdPtr_q;
        if (accept) begin
            if (ptrLow == LAST_ADDR) begin
                rdPtr_d = {~ptrWrap, {(N-1){1'b0}}};
            end else begin
                rdPtr_d = {ptrWrap, ptrLow + ADDR_ONE};
            end
        end
    end

    always_comb begin
        if (ptrWrap == wrWrap) begin
            fill = {1'b0, wrLow - ptrLow};
        end else begin
            fill = DEPTH_N - {1'b0, ptrLow} + {1'b0, wrLow};
        end
    end

    always_ff @(posedge rdClk) begin
        if (rdRst) begin
            rdPtr_q   <= '0;
            rdValid_q <= 1'b0;
        end else begin
            rdPtr_q   <= rdPtr_d;
            rdValid_q <= accept;
        end
    end

    assign bus.rdPtr       = rdPtr_q;
    assign bus.rdAddr      = ptrLow;
    assign bus.memRdEn     = accept;
    assign bus.rdValid     = rdValid_q;
    assign bus.fifoEmpty   = empty;
    assign bus.fillLevel   = fill;
    assign bus.almostEmpty = (32'(fill) <= AE_THRESH);

`ifdef READ_UNIT_UNDERFLOW_EN
    logic underflow_q;

    // Sticky: once a read is attempted on an empty FIFO, only reset clears it.
    always_ff @(posedge rdClk) begin
        if (rdRst) begin
            underflow_q <= 1'b0;
        end else if (bus.rdEn && empty) begin
            underflow_q <= 1'b1;
        end
    end

    assign bus.rdUnderflow = underflow_q;
`else
    assign bus.rdUnderflow = 1'b0;
`endif

endmodule

// File: tb/tb_read_unit.sv
// Self-checking bench for read_unit (N=4, DEPTH=6, AE_THRESH=2) with a reference pointer model and
// queues of expected read addresses / valid strobes.
module tb_read_unit;

    localparam int N     = 4;
    localparam int DEPTH = 6;
    localparam int AE    = 2;
`ifdef READ_UNIT_UNDERFLOW_EN
    localparam bit UNDER_EN = 1'b1;
`else
    localparam bit UNDER_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    read_unit_if #(.N(N)) bus ();

    read_unit #(
        .N         (N),
        .DEPTH     (DEPTH),
        .AE_THRESH (AE)
    ) dut (
        .rdClk (clk),
        .rdRst (rst),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [N-1:0] mPtr   = '0;
    logic         mUnder = 1'b0;
    logic         mEn, mRst, mEmpty;
    logic [N-1:0] mWr;
    logic         expAccept, expEmpty, expAe, expValid;
    logic [N-1:0] expFill;
    logic [N-2:0] expAddr;
    logic [N-2:0] addrQ[$];
    logic         validQ[$];

    function automatic logic [N-1:0] mNext(input logic [N-1:0] p);
        if (p[N-2:0] == (N-1)'(DEPTH - 1)) return {~p[N-1], {(N-1){1'b0}}};
        return {p[N-1], p[N-2:0] + (N-1)'(1)};
    endfunction

    function automatic logic [N-1:0] mFill(input logic [N-1:0] rp, input logic [N-1:0] wp);
        if (rp[N-1] == wp[N-1]) return {1'b0, wp[N-2:0] - rp[N-2:0]};
        return N'(DEPTH) - {1'b0, rp[N-2:0]} + {1'b0, wp[N-2:0]};
    endfunction

    // Drive one cycle of inputs at the falling edge and queue what the DUT should produce.
    task automatic applyStimulus(input logic en, input logic r, input logic [N-1:0] wp);
        @(negedge clk);
        bus.rdEn  = en;
        rst       = r;
        bus.wrPtr = wp;
        mEn       = en;
        mRst      = r;
        mWr       = wp;
        mEmpty    = (mPtr == wp);
        expAccept = en && !mEmpty && !r;
        expEmpty  = mEmpty;
        expFill   = mFill(mPtr, wp);
        expAe     = (int'(expFill) <= AE);
        if (expAccept) addrQ.push_back(mPtr[N-2:0]);
        validQ.push_back(expAccept);
        #1;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        if (mRst) begin
            mPtr   = '0;
            mUnder = 1'b0;
        end else begin
            if (UNDER_EN && mEn && mEmpty) mUnder = 1'b1;
            if (expAccept) mPtr = mNext(mPtr);
        end
        expValid = validQ.pop_front();
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 1'b1, 4'b0000);
        clockEdge();
        compared++;
        if (bus.rdPtr !== 4'd0) begin
            mismatched++; $display("[TB] FAIL reset.rdPtr got %0d exp 0", bus.rdPtr);
        end
        compared++;
        if (bus.rdValid !== 1'b0 || bus.rdUnderflow !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset.valid_under got %b%b exp 00", bus.rdValid, bus.rdUnderflow);
        end
        applyStimulus(1'b1, 1'b0, 4'b0000);
        compared++;
        if (bus.fifoEmpty !== 1'b1 || bus.almostEmpty !== 1'b1 || bus.fillLevel !== 4'd0) begin
            mismatched++; $display("[TB] FAIL reset.flags got e=%b ae=%b fill=%0d exp e=1 ae=1 fill=0",
                                   bus.fifoEmpty, bus.almostEmpty, bus.fillLevel);
        end
        compared++;
        if (bus.memRdEn !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset.memRdEn got %b exp 0", bus.memRdEn);
        end
        clockEdge();
        compared++;
        if (bus.rdValid !== expValid || bus.rdPtr !== mPtr) begin
            mismatched++; $display("[TB] FAIL reset.emptyRead got v=%b p=%0d exp v=%b p=%0d",
                                   bus.rdValid, bus.rdPtr, expValid, mPtr);
        end
        applyStimulus(1'b0, 1'b1, 4'b0000);
        clockEdge();
    endtask

    task automatic test_burst();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 4'b0011);
            compared++;
            if (bus.memRdEn !== expAccept || expAccept !== 1'b1) begin
                mismatched++; $display("[TB] FAIL burst.memRdEn[%0d] got %b exp 1", i, bus.memRdEn);
            end
            if (bus.memRdEn === 1'b1 && addrQ.size() != 0) begin
                expAddr = addrQ.pop_front();
                compared++;
                if (bus.rdAddr !== expAddr || bus.rdAddr !== 3'(i)) begin
                    mismatched++; $display("[TB] FAIL burst.rdAddr[%0d] got %0d exp %0d", i, bus.rdAddr, i);
                end
            end
            compared++;
            if (bus.fillLevel !== expFill) begin
                mismatched++; $display("[TB] FAIL burst.fill[%0d] got %0d exp %0d", i, bus.fillLevel, expFill);
            end
            clockEdge();
            compared++;
            if (bus.rdValid !== expValid || bus.rdPtr !== mPtr) begin
                mismatched++; $display("[TB] FAIL burst.valid_ptr[%0d] got v=%b p=%0d exp v=%b p=%0d",
                                       i, bus.rdValid, bus.rdPtr, expValid, mPtr);
            end
        end
        applyStimulus(1'b1, 1'b0, 4'b0011);
        compared++;
        if (bus.fifoEmpty !== 1'b1 || bus.rdPtr !== 4'd3 || bus.memRdEn !== 1'b0) begin
            mismatched++; $display("[TB] FAIL burst.end got e=%b p=%0d m=%b exp e=1 p=3 m=0",
                                   bus.fifoEmpty, bus.rdPtr, bus.memRdEn);
        end
        clockEdge();
        compared++;
        if (bus.rdValid !== 1'b0 || bus.rdValid !== expValid) begin
            mismatched++; $display("[TB] FAIL burst.tailValid got %b exp 0", bus.rdValid);
        end
    endtask

    // Walk the pointer to the top address and across the wrap while wrPtr moves under it.
    task automatic test_wrap();
        logic [N-1:0] wrSeq[4] = '{4'b0101, 4'b0101, 4'b1001, 4'b1001};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, wrSeq[i]);
            if (i == 2) begin
                compared++;
                if (bus.fillLevel !== 4'd2 || bus.rdAddr !== 3'd5) begin
                    mismatched++; $display("[TB] FAIL wrap.preFill got fill=%0d addr=%0d exp fill=2 addr=5",
                                           bus.fillLevel, bus.rdAddr);
                end
            end
            if (i == 3) begin
                compared++;
                if (bus.fillLevel !== 4'd1 || bus.almostEmpty !== 1'b1 || bus.fifoEmpty !== 1'b0) begin
                    mismatched++; $display("[TB] FAIL wrap.postFill got fill=%0d ae=%b e=%b exp 1 1 0",
                                           bus.fillLevel, bus.almostEmpty, bus.fifoEmpty);
                end
            end
            compared++;
            if (bus.memRdEn !== expAccept || bus.fillLevel !== expFill) begin
                mismatched++; $display("[TB] FAIL wrap.comb[%0d] got m=%b fill=%0d exp m=%b fill=%0d",
                                       i, bus.memRdEn, bus.fillLevel, expAccept, expFill);
            end
            if (bus.memRdEn === 1'b1 && addrQ.size() != 0) begin
                expAddr = addrQ.pop_front();
                compared++;
                if (bus.rdAddr !== expAddr) begin
                    mismatched++; $display("[TB] FAIL wrap.rdAddr[%0d] got %0d exp %0d", i, bus.rdAddr, expAddr);
                end
            end
            clockEdge();
            compared++;
            if (bus.rdValid !== expValid || bus.rdPtr !== mPtr) begin
                mismatched++; $display("[TB] FAIL wrap.valid_ptr[%0d] got v=%b p=%b exp v=%b p=%b",
                                       i, bus.rdValid, bus.rdPtr, expValid, mPtr);
            end
            if (i == 2) begin
                compared++;
                if (bus.rdPtr !== 4'b1000) begin
                    mismatched++; $display("[TB] FAIL wrap.rollover got %b exp 1000", bus.rdPtr);
                end
            end
        end
        applyStimulus(1'b0, 1'b0, 4'b1001);
        compared++;
        if (bus.fifoEmpty !== 1'b1 || bus.rdPtr !== 4'b1001) begin
            mismatched++; $display("[TB] FAIL wrap.drained got e=%b p=%b exp e=1 p=1001", bus.fifoEmpty, bus.rdPtr);
        end
        clockEdge();
    endtask

    task automatic test_full();
        applyStimulus(1'b0, 1'b1, 4'b0000);
        clockEdge();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, (i < 2) ? 4'b0010 : 4'b1010);
            if (i == 2) begin
                compared++;
                if (bus.fillLevel !== 4'd6 || bus.fifoEmpty !== 1'b0 || bus.almostEmpty !== 1'b0) begin
                    mismatched++; $display("[TB] FAIL full.flags got fill=%0d e=%b ae=%b exp 6 0 0",
                                           bus.fillLevel, bus.fifoEmpty, bus.almostEmpty);
                end
            end
            compared++;
            if (bus.memRdEn !== expAccept || bus.almostEmpty !== expAe) begin
                mismatched++; $display("[TB] FAIL full.comb[%0d] got m=%b ae=%b exp m=%b ae=%b",
                                       i, bus.memRdEn, bus.almostEmpty, expAccept, expAe);
            end
            if (bus.memRdEn === 1'b1 && addrQ.size() != 0) begin
                expAddr = addrQ.pop_front();
                compared++;
                if (bus.rdAddr !== expAddr) begin
                    mismatched++; $display("[TB] FAIL full.rdAddr[%0d] got %0d exp %0d", i, bus.rdAddr, expAddr);
                end
            end
            clockEdge();
            compared++;
            if (bus.rdValid !== expValid || bus.rdPtr !== mPtr) begin
                mismatched++; $display("[TB] FAIL full.valid_ptr[%0d] got v=%b p=%b exp v=%b p=%b",
                                       i, bus.rdValid, bus.rdPtr, expValid, mPtr);
            end
        end
        applyStimulus(1'b0, 1'b0, 4'b1010);
        compared++;
        if (bus.fillLevel !== 4'd5 || bus.fillLevel !== expFill) begin
            mismatched++; $display("[TB] FAIL full.afterRead got fill=%0d exp 5", bus.fillLevel);
        end
        clockEdge();
    endtask

    task automatic test_reset_mid();
        applyStimulus(1'b1, 1'b0, 4'b1010);
        if (bus.memRdEn === 1'b1 && addrQ.size() != 0) begin
            expAddr = addrQ.pop_front();
            compared++;
            if (bus.rdAddr !== expAddr) begin
                mismatched++; $display("[TB] FAIL rstMid.rdAddr got %0d exp %0d", bus.rdAddr, expAddr);
            end
        end
        clockEdge();
        compared++;
        if (bus.rdValid !== 1'b1 || bus.rdValid !== expValid) begin
            mismatched++; $display("[TB] FAIL rstMid.preValid got %b exp 1", bus.rdValid);
        end
        applyStimulus(1'b1, 1'b1, 4'b1010);
        compared++;
        if (bus.memRdEn !== 1'b0) begin
            mismatched++; $display("[TB] FAIL rstMid.memRdEn got %b exp 0", bus.memRdEn);
        end
        clockEdge();
        compared++;
        if (bus.rdPtr !== 4'd0 || bus.rdValid !== 1'b0 || bus.rdValid !== expValid) begin
            mismatched++; $display("[TB] FAIL rstMid.post got p=%0d v=%b exp p=0 v=0", bus.rdPtr, bus.rdValid);
        end
        applyStimulus(1'b0, 1'b0, 4'b0000);
        clockEdge();
        compared++;
        if (bus.rdValid !== 1'b0) begin
            mismatched++; $display("[TB] FAIL rstMid.idleValid got %b exp 0", bus.rdValid);
        end
    endtask

    task automatic test_underflow();
        applyStimulus(1'b1, 1'b0, 4'b0000);
        compared++;
        if (bus.memRdEn !== 1'b0 || bus.fifoEmpty !== 1'b1) begin
            mismatched++; $display("[TB] FAIL under.comb got m=%b e=%b exp m=0 e=1", bus.memRdEn, bus.fifoEmpty);
        end
        clockEdge();
        compared++;
        if (bus.rdUnderflow !== mUnder || bus.rdUnderflow !== UNDER_EN) begin
            mismatched++; $display("[TB] FAIL under.set got %b exp %b", bus.rdUnderflow, UNDER_EN);
        end
        compared++;
        if (bus.rdValid !== 1'b0 || bus.rdPtr !== 4'd0) begin
            mismatched++; $display("[TB] FAIL under.noRead got v=%b p=%0d exp v=0 p=0", bus.rdValid, bus.rdPtr);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 4'b0000);
            clockEdge();
            compared++;
            if (bus.rdUnderflow !== mUnder) begin
                mismatched++; $display("[TB] FAIL under.hold[%0d] got %b exp %b", i, bus.rdUnderflow, mUnder);
            end
        end
        applyStimulus(1'b0, 1'b1, 4'b0000);
        clockEdge();
        compared++;
        if (bus.rdUnderflow !== 1'b0) begin
            mismatched++; $display("[TB] FAIL under.clear got %b exp 0", bus.rdUnderflow);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.rdEn  = 1'b0;
        bus.wrPtr = '0;
        test_reset();
        test_burst();
        test_wrap();
        test_full();
        test_reset_mid();
        test_underflow();
        compared++;
        if (addrQ.size() != 0 || validQ.size() != 0) begin
            mismatched++; $display("[TB] FAIL scoreboard.leftover got addr=%0d valid=%0d exp 0 0",
                                   addrQ.size(), validQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
